// File: rtl/ram_port_arbiter_if.sv
// One requester port of the shared single-port RAM: request/grant handshake,
// write payload and the one-cycle-latency read response.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 22,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [BE_WIDTH-1:0]   be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  // Core side drives the request, arbiter side answers it.
  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between the instruction port (p0, default
// priority) and the data port (p1). p1 wins after STARVE_LIMIT lost conflicts.
// Responses are routed back to the port that owned the access one cycle earlier.
module ram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 22,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  ram_port_arbiter_if.slave       p0,
  ram_port_arbiter_if.slave       p1,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic [31:0]             conflict_cnt_o
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_sel_q, resp_sel_d;
  logic [31:0]         conflict_q, conflict_d;
  logic                gnt0_c, gnt1_c;
  logic                both_c;

  // Same-cycle grant: p0 by default, p1 when it has lost STARVE_LIMIT conflicts in a row.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    both_c = p0.req && p1.req;
    if (both_c) begin
      if (starve_q == STARVE_MAX) gnt1_c = 1'b1;
      else                        gnt0_c = 1'b1;
    end else if (p0.req) begin
      gnt0_c = 1'b1;
    end else if (p1.req) begin
      gnt1_c = 1'b1;
    end
  end

  // RAM request mux; bus is zeroed when idle so nothing stale reaches the RAM.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (gnt1_c) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = p1.addr;
      ram_we_o    = p1.we;
      ram_be_o    = p1.be;
      ram_wdata_o = p1.wdata;
    end else if (gnt0_c) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = p0.addr;
      ram_we_o    = p0.we;
      ram_be_o    = p0.be;
      ram_wdata_o = p0.wdata;
    end
  end

  // Next state for starvation, response ownership and the saturating conflict count.
  always_comb begin
    starve_d     = '0;
    resp_valid_d = gnt0_c || gnt1_c;
    resp_sel_d   = resp_sel_q;
    conflict_d   = conflict_q;
    if (p1.req && !gnt1_c) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_W'(1);
    end
    if (gnt0_c || gnt1_c) resp_sel_d = gnt1_c;
    if (both_c && (conflict_q != CNT_MAX)) conflict_d = conflict_q + 32'd1;
  end

  // State registers; reset drops any response still in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_sel_q   <= 1'b0;
      conflict_q   <= '0;
    end else begin
      starve_q     <= starve_d;
      resp_valid_q <= resp_valid_d;
      resp_sel_q   <= resp_sel_d;
      conflict_q   <= conflict_d;
    end
  end

  assign p0.gnt         = gnt0_c;
  assign p1.gnt         = gnt1_c;
  assign p0.rvalid      = resp_valid_q && !resp_sel_q;
  assign p1.rvalid      = resp_valid_q && resp_sel_q;
  assign p0.rdata       = ram_rdata_i;
  assign p1.rdata       = ram_rdata_i;
  assign conflict_cnt_o = conflict_q;

  logic unused_be_w;
  assign unused_be_w = (BE_WIDTH == 0);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: table vectors, directed corner sequences and
// random traffic checked against a rule-level model with a shadow memory.
module tb_ram_port_arbiter;
  localparam int unsigned AW = 22;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int LIM = 3;

  typedef struct packed {
    logic          req;
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    bit r0;
    bit r1;
    bit e0;
    bit e1;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p0_if ();
  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p1_if ();

  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [31:0]   conflict_cnt;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .p0             (p0_if),
    .p1             (p1_if),
    .ram_en_o       (ram_en),
    .ram_addr_o     (ram_addr),
    .ram_we_o       (ram_we),
    .ram_be_o       (ram_be),
    .ram_wdata_o    (ram_wdata),
    .ram_rdata_i    (ram_rdata),
    .conflict_cnt_o (conflict_cnt)
  );

  // Single-port RAM with one-cycle read latency, driven only by the DUT.
  logic [DW-1:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < int'(BW); b++)
          if (ram_be[b]) ram_mem[ram_addr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else begin
        ram_rdata <= ram_mem[ram_addr[7:0]];
      end
    end
  end

  // Reference model state
  int          total = 0;
  int          bad   = 0;
  int          m_loss;
  logic [31:0] m_conf;
  bit          m_pend, m_sel, m_rd_known;
  logic [DW-1:0] m_rd_exp;
  logic [DW-1:0] ref_mem [256];
  bit          ref_ok [256];
  bit          act_g0, act_g1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input bit r, input int a, input bit w, input logic [BW-1:0] be,
                              input logic [DW-1:0] d);
    req_t q;
    q.req = r; q.addr = AW'(a); q.we = w; q.be = be; q.wdata = d;
    return q;
  endfunction

  task automatic drive(input req_t q0, input req_t q1);
    p0_if.req = q0.req; p0_if.addr = q0.addr; p0_if.we = q0.we; p0_if.be = q0.be; p0_if.wdata = q0.wdata;
    p1_if.req = q1.req; p1_if.addr = q1.addr; p1_if.we = q1.we; p1_if.be = q1.be; p1_if.wdata = q1.wdata;
  endtask

  task automatic model_reset();
    m_loss = 0; m_conf = '0; m_pend = 0; m_sel = 0; m_rd_known = 0;
  endtask

  // One clock cycle: apply requests, check every output against the model, advance the model.
  task automatic step(input req_t q0, input req_t q1);
    bit g0, g1;
    req_t gq;
    int idx;
    @(negedge clk);
    drive(q0, q1);
    #1;
    chk("p0_rvalid", 64'(p0_if.rvalid), 64'(m_pend && !m_sel));
    chk("p1_rvalid", 64'(p1_if.rvalid), 64'(m_pend && m_sel));
    if (m_pend && m_rd_known) begin
      if (m_sel) chk("p1_rdata", 64'(p1_if.rdata), 64'(m_rd_exp));
      else       chk("p0_rdata", 64'(p0_if.rdata), 64'(m_rd_exp));
    end
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_conf));
    g1 = q1.req && (!q0.req || m_loss == LIM);
    g0 = q0.req && !g1;
    act_g0 = p0_if.gnt;
    act_g1 = p1_if.gnt;
    chk("p0_gnt", 64'(p0_if.gnt), 64'(g0));
    chk("p1_gnt", 64'(p1_if.gnt), 64'(g1));
    gq = g1 ? q1 : q0;
    if (g0 || g1)
      chk("ram_bus", 64'({ram_en, ram_addr, ram_we, ram_be, ram_wdata}),
          64'({1'b1, gq.addr, gq.we, gq.be, gq.wdata}));
    else
      chk("ram_idle", 64'({ram_en, ram_addr, ram_we, ram_be, ram_wdata}), 64'd0);
    m_pend = g0 || g1;
    m_sel = g1;
    m_rd_known = 0;
    if (g0 || g1) begin
      idx = int'(gq.addr[7:0]);
      if (gq.we) begin
        if (ref_ok[idx] || gq.be == '1) begin
          for (int b = 0; b < int'(BW); b++)
            if (gq.be[b]) ref_mem[idx][b*8 +: 8] = gq.wdata[b*8 +: 8];
          ref_ok[idx] = 1;
        end
      end else begin
        m_rd_known = ref_ok[idx];
        m_rd_exp = ref_mem[idx];
      end
    end
    if (q0.req && q1.req && m_conf != 32'hFFFF_FFFF) m_conf = m_conf + 32'd1;
    m_loss = (q1.req && !g1) ? m_loss + 1 : 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(mk(0, 0, 0, '0, '0), mk(0, 0, 0, '0, '0));
    rstn = 1'b0;
    model_reset();
    #1;
    chk("rst_p0_rvalid", 64'(p0_if.rvalid), 64'd0);
    chk("rst_p1_rvalid", 64'(p1_if.rvalid), 64'd0);
    chk("rst_conflict", 64'(conflict_cnt), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    req_t idle, a, b;
    vec_t tbl[$];
    idle = mk(0, 0, 0, '0, '0);
    for (int i = 0; i < 256; i++) ref_ok[i] = 0;
    rstn = 1'b0;
    drive(idle, idle);
    model_reset();
    do_reset();

    // Idle after reset
    for (int i = 0; i < 5; i++) step(idle, idle);

    // p1 single-port write then read
    step(idle, mk(1, 'h10, 1, 4'hF, 32'hDEADBEEF));
    step(idle, mk(1, 'h10, 0, 4'h0, 32'h0));
    step(idle, idle);
    chk("p1_read_deadbeef", 64'(p1_if.rdata), 64'h0000_0000_DEAD_BEEF);

    // Starvation override table: both ports request continuously
    for (int i = 0; i < 8; i++) tbl.push_back('{1, 1, (i % 4) != 3, (i % 4) == 3});
    do_reset();
    foreach (tbl[i]) begin
      step(mk(tbl[i].r0, 'h20, 0, '0, '0), mk(tbl[i].r1, 'h24, 0, '0, '0));
      chk("starve_tbl_gnt", 64'({act_g0, act_g1}), 64'({tbl[i].e0, tbl[i].e1}));
    end
    step(idle, idle);
    chk("conflict_after_8", 64'(conflict_cnt), 64'd8);

    // Counter clear: p1 dropping resets its starvation history
    tbl.delete();
    tbl.push_back('{1, 1, 1, 0});
    tbl.push_back('{1, 1, 1, 0});
    tbl.push_back('{1, 0, 1, 0});
    tbl.push_back('{1, 1, 1, 0});
    tbl.push_back('{1, 1, 1, 0});
    tbl.push_back('{1, 1, 1, 0});
    tbl.push_back('{1, 1, 0, 1});
    do_reset();
    foreach (tbl[i]) begin
      step(mk(tbl[i].r0, 'h20, 0, '0, '0), mk(tbl[i].r1, 'h24, 0, '0, '0));
      chk("clear_tbl_gnt", 64'({act_g0, act_g1}), 64'({tbl[i].e0, tbl[i].e1}));
    end
    step(idle, idle);

    // Reset while a p0 read is in flight
    step(mk(1, 'h10, 0, '0, '0), idle);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("midrst_p0_gnt_comb", 64'(p0_if.gnt), 64'd1);
    chk("midrst_conflict", 64'(conflict_cnt), 64'd0);
    @(negedge clk);
    drive(idle, idle);
    rstn = 1'b1;
    step(idle, idle);
    chk("midrst_no_rvalid", 64'(p0_if.rvalid), 64'd0);

    // Response routing with alternating ports
    step(mk(1, 'h4, 1, 4'hF, 32'h11111111), idle);
    step(idle, mk(1, 'h8, 1, 4'hF, 32'h22222222));
    for (int i = 0; i < 4; i++) begin
      a = mk(1, 'h4, 0, '0, '0);
      b = mk(1, 'h8, 0, '0, '0);
      if (i % 2 == 0) step(a, idle);
      else            step(idle, b);
    end
    step(idle, idle);
    chk("route_last_p1_data", 64'(p1_if.rdata), 64'h0000_0000_2222_2222);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      a = mk($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
             BW'($urandom), DW'($urandom));
      b = mk($urandom_range(0, 2) != 0, int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
             BW'($urandom), DW'($urandom));
      step(a, b);
    end
    step(idle, idle);
    step(idle, idle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
